// File: rtl/countdown_timer_cnt.sv
// Countdown timer: loads a clamped min:sec:csec preset and counts it down once per
// falling edge of the 100 Hz pulse, with run/pause control and an expiry pulse and level.
module countdown_timer_cnt #(
    parameter int CSEC_MAX = 99,
    parameter int SEC_MAX  = 59,
    parameter int MIN_MAX  = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
    input  logic [6:0] set_csec,
    input  logic       run,
    input  logic       plsi,
    output logic [6:0] csec,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic       running,
    output logic       done,
    output logic       expired
);

    localparam logic [6:0] CSEC_TOP = 7'(CSEC_MAX);
    localparam logic [5:0] SEC_TOP  = 6'(SEC_MAX);
    localparam logic [5:0] MIN_TOP  = 6'(MIN_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       load_q, plsi_q;
    logic [6:0] csec_q, csec_d;
    logic [5:0] sec_q, sec_d;
    logic [5:0] min_q, min_d;
    logic       done_q, done_d;
    logic       load_edge_s, tick_s, count_zero_s, count_last_s;

    assign load_edge_s  = load & ~load_q;
    assign tick_s       = plsi_q & ~plsi;
    assign count_zero_s = (min_q == 6'd0) && (sec_q == 6'd0) && (csec_q == 7'd0);
    assign count_last_s = (min_q == 6'd0) && (sec_q == 6'd0) && (csec_q == 7'd1);

    // Next-state, counter update and done pulse; a load edge overrides everything.
    always_comb begin
        state_d = state_q;
        csec_d  = csec_q;
        sec_d   = sec_q;
        min_d   = min_q;
        done_d  = 1'b0;
        if (load_edge_s) begin
            csec_d  = (set_csec > CSEC_TOP) ? CSEC_TOP : set_csec;
            sec_d   = (set_sec > SEC_TOP) ? SEC_TOP : set_sec;
            min_d   = (set_min > MIN_TOP) ? MIN_TOP : set_min;
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run && !count_zero_s) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (tick_s && !count_zero_s) begin
                        // Borrow ripples csec -> sec -> min; min is nonzero whenever it is reached
                        if (csec_q != 7'd0) begin
                            csec_d = csec_q - 7'd1;
                        end else begin
                            csec_d = CSEC_TOP;
                            if (sec_q != 6'd0) begin
                                sec_d = sec_q - 6'd1;
                            end else begin
                                sec_d = SEC_TOP;
                                min_d = min_q - 6'd1;
                            end
                        end
                        if (count_last_s) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else if (!run) begin
                            state_d = S_PAUSE;
                        end else begin
                            state_d = S_RUN;
                        end
                    end else if (!run) begin
                        state_d = S_PAUSE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_PAUSE: begin
                    if (run) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_PAUSE;
                    end
                end
                S_DONE: begin
                    if (!run) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, counters, edge-detect flops and done pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            csec_q  <= 7'd0;
            sec_q   <= 6'd0;
            min_q   <= 6'd0;
            done_q  <= 1'b0;
            load_q  <= 1'b0;
            plsi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            csec_q  <= csec_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            done_q  <= done_d;
            load_q  <= load;
            plsi_q  <= plsi;
        end
    end

    assign csec    = csec_q;
    assign sec     = sec_q;
    assign min     = min_q;
    assign done    = done_q;
    assign running = (state_q == S_RUN);
    assign expired = (state_q == S_DONE);

endmodule

// File: tb/tb_countdown_timer_cnt.sv
// Randomised bench for countdown_timer_cnt: a total-centisecond reference model checked
// every cycle, plus literal checkpoints taken from the directed scenarios.
module tb_countdown_timer_cnt;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [5:0] set_min = 6'd0;
    logic [5:0] set_sec = 6'd0;
    logic [6:0] set_csec = 7'd0;
    logic       run = 1'b0;
    logic       plsi = 1'b0;
    logic [6:0] csec;
    logic [5:0] sec;
    logic [5:0] min;
    logic       running, done, expired;

    int checks = 0;
    int errors = 0;

    countdown_timer_cnt dut (
        .clk(clk), .rst(rst), .load(load), .set_min(set_min), .set_sec(set_sec),
        .set_csec(set_csec), .run(run), .plsi(plsi), .csec(csec), .sec(sec),
        .min(min), .running(running), .done(done), .expired(expired)
    );

    always #5 clk = ~clk;

    // Reference model: count held as total centiseconds, mode 0 idle, 1 run, 2 pause, 3 done.
    int m_tot = 0;
    int m_mode = 0;
    bit m_done = 1'b0;
    bit p_load = 1'b0;
    bit p_plsi = 1'b0;
    bit chk_en = 1'b0;

    function automatic int clamp_total(int mi, int se, int cs);
        int a, b, c;
        a = (mi > 59) ? 59 : mi;
        b = (se > 59) ? 59 : se;
        c = (cs > 99) ? 99 : cs;
        return a * 6000 + b * 100 + c;
    endfunction

    // Model update at each active edge.
    always @(posedge clk) begin : model
        bit le, tk;
        le = load && !p_load;
        tk = p_plsi && !plsi;
        if (rst) begin
            m_tot = 0; m_mode = 0; m_done = 1'b0; p_load = 1'b0; p_plsi = 1'b0;
            chk_en = 1'b1;
        end else begin
            p_load = load;
            p_plsi = plsi;
            m_done = 1'b0;
            if (le) begin
                m_tot  = clamp_total(int'(set_min), int'(set_sec), int'(set_csec));
                m_mode = 0;
            end else if (m_mode == 0) begin
                if (run && m_tot != 0) m_mode = 1;
            end else if (m_mode == 1) begin
                if (tk && m_tot > 0) begin
                    m_tot = m_tot - 1;
                    if (m_tot == 0) begin
                        m_mode = 3; m_done = 1'b1;
                    end else if (!run) begin
                        m_mode = 2;
                    end
                end else if (!run) begin
                    m_mode = 2;
                end
            end else if (m_mode == 2) begin
                if (run) m_mode = 1;
            end else begin
                if (!run) m_mode = 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            int em, es, ec;
            em = m_tot / 6000;
            es = (m_tot / 100) % 60;
            ec = m_tot % 100;
            checks++;
            if (int'(min) != em || int'(sec) != es || int'(csec) != ec ||
                running != (m_mode == 1) || expired != (m_mode == 3) || done != m_done) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t got %0d:%0d:%0d run=%0b exp=%0b done=%0b want %0d:%0d:%0d run=%0b exp=%0b done=%0b",
                         $time, min, sec, csec, running, expired, done,
                         em, es, ec, (m_mode == 1), (m_mode == 3), m_done);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int mi, input int se, input int cs);
        set_min = 6'(mi); set_sec = 6'(se); set_csec = 7'(cs);
        load = 1'b1; step();
        load = 1'b0; step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            plsi = 1'b1; step();
            plsi = 1'b0; step();
        end
    endtask

    task automatic lit(input string nm, input int mi, input int se, input int cs,
                       input bit r, input bit e, input bit d);
        @(negedge clk);
        checks++;
        if (int'(min) != mi || int'(sec) != se || int'(csec) != cs ||
            running != r || expired != e || done != d) begin
            errors++;
            $display("FAIL %s got %0d:%0d:%0d run=%0b exp=%0b done=%0b want %0d:%0d:%0d run=%0b exp=%0b done=%0b",
                     nm, min, sec, csec, running, expired, done, mi, se, cs, r, e, d);
        end
    endtask

    initial begin
        step(); step();
        rst = 1'b0;
        // Reset after a load
        do_load(1, 2, 3);
        lit("load_123", 1, 2, 3, 1'b0, 1'b0, 1'b0);
        rst = 1'b1; step(); rst = 1'b0;
        lit("reset", 0, 0, 0, 1'b0, 1'b0, 1'b0);
        // Borrow chain and expiry
        run = 1'b1;
        do_load(1, 0, 0);
        ticks(1);
        lit("borrow", 0, 59, 99, 1'b1, 1'b0, 1'b0);
        do_load(0, 0, 5);
        ticks(5);
        lit("expire", 0, 0, 0, 1'b0, 1'b1, 1'b1);
        step();
        lit("done_len", 0, 0, 0, 1'b0, 1'b1, 1'b0);
        // Pause
        do_load(0, 0, 50);
        ticks(10);
        lit("run10", 0, 0, 40, 1'b1, 1'b0, 1'b0);
        run = 1'b0; step();
        ticks(20);
        lit("paused", 0, 0, 40, 1'b0, 1'b0, 1'b0);
        run = 1'b1;
        ticks(40);
        lit("resume_exp", 0, 0, 0, 1'b0, 1'b1, 1'b1);
        // Clamp and load/tick collision
        do_load(63, 60, 120);
        lit("clamp", 59, 59, 99, 1'b1, 1'b0, 1'b0);
        set_min = 6'd0; set_sec = 6'd10; set_csec = 7'd0;
        plsi = 1'b1; step();
        plsi = 1'b0; load = 1'b1; step();
        lit("collide", 0, 10, 0, 1'b0, 1'b0, 1'b0);
        load = 1'b0; run = 1'b0; step();
        // Zero start
        do_load(0, 0, 0);
        run = 1'b1; step(); step();
        lit("zero_start", 0, 0, 0, 1'b0, 1'b0, 1'b0);
        do_load(0, 0, 2);
        ticks(2);
        lit("exp2", 0, 0, 0, 1'b0, 1'b1, 1'b1);
        // Ticks in DONE, then leave DONE
        ticks(3);
        lit("done_hold", 0, 0, 0, 1'b0, 1'b1, 1'b0);
        run = 1'b0; step();
        lit("done_exit", 0, 0, 0, 1'b0, 1'b0, 1'b0);
        // Reset mid-count
        run = 1'b1;
        do_load(0, 30, 0);
        lit("pre_rst", 0, 30, 0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1; step(); rst = 1'b0;
        lit("mid_rst", 0, 0, 0, 1'b0, 1'b0, 1'b0);
        // Random phase
        for (int i = 0; i < 4000; i++) begin
            rst  = ($urandom_range(0, 499) == 0);
            load = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 0) begin
                set_min = 6'd0; set_sec = 6'd0;
                set_csec = 7'($urandom_range(0, 127));
            end else begin
                set_min = 6'($urandom_range(0, 63));
                set_sec = 6'($urandom_range(0, 63));
                set_csec = 7'($urandom_range(0, 127));
            end
            if ($urandom_range(0, 29) == 0) run = ~run;
            plsi = ($urandom_range(0, 2) == 0);
            step();
        end
        rst = 1'b0; load = 1'b0; plsi = 1'b0;
        step(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
